// File: rtl/fse_cplx_os.sv
// Fractionally spaced complex FIR equalizer: NUM_TAPS complex taps, OS samples/symbol,
// round-half-up + saturating output, tap updates deferred to the next symbol boundary.

module fse_tap #(
  parameter int NBT_IN   = 8,
  parameter int NBT_TAPS = 28
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic signed [NBT_IN-1:0]        x_i,
  input  logic signed [NBT_IN-1:0]        x_q,
  input  logic signed [NBT_TAPS-1:0]      h_i,
  input  logic signed [NBT_TAPS-1:0]      h_q,
  output logic signed [NBT_IN+NBT_TAPS:0] p_i,
  output logic signed [NBT_IN+NBT_TAPS:0] p_q
);
  localparam int PW = NBT_IN + NBT_TAPS;

  logic signed [PW-1:0] ii, qq, iq, qi;

  assign ii = PW'(x_i) * PW'(h_i);
  assign qq = PW'(x_q) * PW'(h_q);
  assign iq = PW'(x_i) * PW'(h_q);
  assign qi = PW'(x_q) * PW'(h_i);

  // One extra bit absorbs the add/subtract of the two partial products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_i <= '0;
      p_q <= '0;
    end else if (en) begin
      p_i <= {ii[PW-1], ii} - {qq[PW-1], qq};
      p_q <= {iq[PW-1], iq} + {qi[PW-1], qi};
    end
  end
endmodule

module fse_cplx_os #(
  parameter int NUM_TAPS = 11,
  parameter int OS       = 2,
  parameter int NBT_IN   = 8,
  parameter int NBF_IN   = 7,
  parameter int NBT_TAPS = 28,
  parameter int NBF_TAPS = 25,
  parameter int NBT_OUT  = 12,
  parameter int NBF_OUT  = 9
) (
  input  logic                             clk,
  input  logic                             i_reset_n,
  input  logic                             i_en,
  input  logic signed [NBT_IN-1:0]         i_is_data_I,
  input  logic signed [NBT_IN-1:0]         i_is_data_Q,
  input  logic [NUM_TAPS*NBT_TAPS-1:0]     i_taps_I,
  input  logic [NUM_TAPS*NBT_TAPS-1:0]     i_taps_Q,
  input  logic                             i_taps_load,
  input  logic                             i_clr_sat,
  output logic signed [NBT_OUT-1:0]        o_os_data_I,
  output logic signed [NBT_OUT-1:0]        o_os_data_Q,
  output logic                             o_valid,
  output logic                             o_sym_valid,
  output logic                             o_taps_pending,
  output logic                             o_sat
);
  localparam int STAGES = 2;
  localparam int PW     = NBT_IN + NBT_TAPS;
  localparam int CW     = PW + 1;
  localparam int AW     = PW + $clog2(NUM_TAPS) + 1;
  localparam int RW     = AW + 1;
  localparam int D      = NBF_IN + NBF_TAPS - NBF_OUT;
  localparam int DM1    = (D > 0) ? D - 1 : 0;
  localparam int PHW    = (OS > 1) ? $clog2(OS) : 1;
  localparam logic signed [RW-1:0] RND  = (D > 0) ? (RW'(1) << DM1) : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-NBT_OUT+1){1'b0}}, {(NBT_OUT-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic [NUM_TAPS-1:0][NBT_IN-1:0] x_i, x_q;
  logic [NUM_TAPS*NBT_TAPS-1:0]    act_i, act_q, shd_i, shd_q;
  logic signed [CW-1:0]            p_i [NUM_TAPS];
  logic signed [CW-1:0]            p_q [NUM_TAPS];
  logic signed [AW-1:0]            acc_i, acc_q;
  logic [NBT_OUT:0]                q_i, q_q;
  logic [PHW-1:0]                  phase;
  logic [STAGES:0]                 vld_pipe, ph0_pipe;
  logic                            boundary;

  assign boundary    = i_en && (phase == '0);
  assign o_valid     = vld_pipe[STAGES];
  assign o_sym_valid = vld_pipe[STAGES] & ph0_pipe[STAGES];

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_i      <= '0;
      x_q      <= '0;
      phase    <= '0;
      vld_pipe <= '0;
      ph0_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], i_en};
      ph0_pipe <= {ph0_pipe[STAGES-1:0], boundary};
      if (i_en) begin
        x_i[0] <= i_is_data_I;
        x_q[0] <= i_is_data_Q;
        for (int k = 1; k < NUM_TAPS; k++) begin
          x_i[k] <= x_i[k-1];
          x_q[k] <= x_q[k-1];
        end
        phase <= (phase == PHW'(OS - 1)) ? '0 : phase + 1'b1;
      end
    end
  end

  // Load on a symbol boundary goes straight to the active set; otherwise it waits in shadow.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      act_i          <= '0;
      act_q          <= '0;
      shd_i          <= '0;
      shd_q          <= '0;
      o_taps_pending <= 1'b0;
    end else begin
      if (i_taps_load) begin
        shd_i <= i_taps_I;
        shd_q <= i_taps_Q;
      end
      if (i_taps_load && boundary) begin
        act_i          <= i_taps_I;
        act_q          <= i_taps_Q;
        o_taps_pending <= 1'b0;
      end else if (i_taps_load) begin
        o_taps_pending <= 1'b1;
      end else if (boundary && o_taps_pending) begin
        act_i          <= shd_i;
        act_q          <= shd_q;
        o_taps_pending <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    fse_tap #(.NBT_IN(NBT_IN), .NBT_TAPS(NBT_TAPS)) u_tap (
      .clk  (clk),
      .rst_n(i_reset_n),
      .en   (vld_pipe[0]),
      .x_i  (x_i[k]),
      .x_q  (x_q[k]),
      .h_i  (act_i[k*NBT_TAPS +: NBT_TAPS]),
      .h_q  (act_q[k*NBT_TAPS +: NBT_TAPS]),
      .p_i  (p_i[k]),
      .p_q  (p_q[k])
    );
  end

  always_comb begin
    acc_i = '0;
    acc_q = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc_i = acc_i + AW'(p_i[k]);
      acc_q = acc_q + AW'(p_q[k]);
    end
  end

  // Returns {clipped, value}.
  function automatic logic [NBT_OUT:0] quant(input logic signed [AW-1:0] acc);
    logic signed [RW-1:0] r;
    r = (RW'(acc) + RND) >>> D;
    if (r > MAXV) return {2'b10, {(NBT_OUT-1){1'b1}}};
    if (r < MINV) return {2'b11, {(NBT_OUT-1){1'b0}}};
    return {1'b0, r[NBT_OUT-1:0]};
  endfunction

  assign q_i = quant(acc_i);
  assign q_q = quant(acc_q);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_os_data_I <= '0;
      o_os_data_Q <= '0;
      o_sat       <= 1'b0;
    end else begin
      if (vld_pipe[1]) begin
        o_os_data_I <= q_i[NBT_OUT-1:0];
        o_os_data_Q <= q_q[NBT_OUT-1:0];
      end
      o_sat <= (o_sat & ~i_clr_sat) | (vld_pipe[1] & (q_i[NBT_OUT] | q_q[NBT_OUT]));
    end
  end
endmodule

// File: tb/tb_fse_cplx_os.sv
// Bench for fse_cplx_os: directed cases plus a randomized stream checked against
// a transaction-level model (history arrays, tap sets and a timed result queue).
module tb_fse_cplx_os;
  localparam int NT = 11, OS = 2, TW = 28, D = 23, OMAX = 2047, OMIN = -2048;
  localparam int ONE = 32'h2000000;

  logic clk, rst_n, en, load, clr;
  logic signed [7:0] di, dq;
  logic [NT*TW-1:0] taps_i, taps_q;
  logic signed [11:0] oi, oq;
  logic ov, osv, opend, osat;
  int errs = 0, checks = 0;

  fse_cplx_os dut (
    .clk(clk), .i_reset_n(rst_n), .i_en(en),
    .i_is_data_I(di), .i_is_data_Q(dq),
    .i_taps_I(taps_i), .i_taps_Q(taps_q),
    .i_taps_load(load), .i_clr_sat(clr),
    .o_os_data_I(oi), .o_os_data_Q(oq),
    .o_valid(ov), .o_sym_valid(osv), .o_taps_pending(opend), .o_sat(osat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct { longint rdy; int yi; int yq; bit ph0; bit clip; } ent_t;
  ent_t   mq[$];
  longint cyc;
  int     hist_i[NT], hist_q[NT];
  longint act_i[NT], act_q[NT], shd_i[NT], shd_q[NT];
  int     m_ph, m_i, m_q;
  bit     m_pend, m_valid, m_sym, m_sat;

  function automatic longint tap_of(input logic [NT*TW-1:0] bus, input int k);
    return longint'($signed(bus[k*TW +: TW]));
  endfunction

  function automatic longint rnd(input longint acc);
    longint half;
    half = longint'(1) << (D - 1);
    return (acc + half) >>> D;
  endfunction

  task automatic model_reset();
    mq.delete();
    cyc = 0; m_ph = 0; m_i = 0; m_q = 0;
    m_pend = 0; m_valid = 0; m_sym = 0; m_sat = 0;
    for (int k = 0; k < NT; k++) begin
      hist_i[k] = 0; hist_q[k] = 0; act_i[k] = 0; act_q[k] = 0; shd_i[k] = 0; shd_q[k] = 0;
    end
  endtask

  // Predicts the effect of the coming rising edge from the inputs currently driven.
  task automatic model_edge();
    ent_t e; longint ai, aq, ri, rq; bit bnd;
    if (!rst_n) return;
    cyc++;
    m_valid = 0; m_sym = 0;
    if (clr) m_sat = 0;
    if (mq.size() > 0 && mq[0].rdy == cyc) begin
      e = mq.pop_front();
      m_valid = 1; m_sym = e.ph0; m_i = e.yi; m_q = e.yq;
      if (e.clip) m_sat = 1;
    end
    bnd = en && (m_ph == 0);
    if (load) begin
      for (int k = 0; k < NT; k++) begin shd_i[k] = tap_of(taps_i, k); shd_q[k] = tap_of(taps_q, k); end
      m_pend = 1;
    end
    if (bnd && m_pend) begin
      for (int k = 0; k < NT; k++) begin act_i[k] = shd_i[k]; act_q[k] = shd_q[k]; end
      m_pend = 0;
    end
    if (en) begin
      for (int k = NT - 1; k > 0; k--) begin hist_i[k] = hist_i[k-1]; hist_q[k] = hist_q[k-1]; end
      hist_i[0] = int'(di); hist_q[0] = int'(dq);
      ai = 0; aq = 0;
      for (int k = 0; k < NT; k++) begin
        ai += longint'(hist_i[k]) * act_i[k] - longint'(hist_q[k]) * act_q[k];
        aq += longint'(hist_i[k]) * act_q[k] + longint'(hist_q[k]) * act_i[k];
      end
      ri = rnd(ai); rq = rnd(aq);
      e.clip = (ri > OMAX) || (ri < OMIN) || (rq > OMAX) || (rq < OMIN);
      e.yi = (ri > OMAX) ? OMAX : (ri < OMIN) ? OMIN : int'(ri);
      e.yq = (rq > OMAX) ? OMAX : (rq < OMIN) ? OMIN : int'(rq);
      e.rdy = cyc + 2; e.ph0 = (m_ph == 0);
      mq.push_back(e);
      m_ph = (m_ph + 1) % OS;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; load = 0; clr = 0; di = 0; dq = 0;
    model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic set_tap(input bit rail_q, input int k, input int val);
    logic [TW-1:0] v;
    v = val[TW-1:0];
    if (rail_q) taps_q[k*TW +: TW] = v;
    else        taps_i[k*TW +: TW] = v;
  endtask

  // Accept one sample, then idle until its output has appeared.
  task automatic push(input int xi, input int xq, input bit ld, output bit v, output int yi, output int yq);
    en = 1; di = xi[7:0]; dq = xq[7:0]; load = ld;
    tick();
    en = 0; di = 0; dq = 0; load = 0;
    tick(); tick();
    v = ov; yi = oi; yq = oq;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; en = 0; load = 0; clr = 0; di = 0; dq = 0; taps_i = '0; taps_q = '0;
    model_reset();
    @(negedge clk); #1;
    checks++; if (ov !== 1'b0)    begin errs++; $display("FAIL rst_valid: got %b want 0", ov); end
    checks++; if (osv !== 1'b0)   begin errs++; $display("FAIL rst_sym: got %b want 0", osv); end
    checks++; if (oi !== 12'sd0)  begin errs++; $display("FAIL rst_I: got %0d want 0", oi); end
    checks++; if (oq !== 12'sd0)  begin errs++; $display("FAIL rst_Q: got %0d want 0", oq); end
    checks++; if (osat !== 1'b0)  begin errs++; $display("FAIL rst_sat: got %b want 0", osat); end
    checks++; if (opend !== 1'b0) begin errs++; $display("FAIL rst_pend: got %b want 0", opend); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_impulse();
    bit v; int yi, yq;
    do_reset();
    taps_i = '0; taps_q = '0; set_tap(0, 5, ONE);
    load = 1; tick(); load = 0;
    for (int j = 0; j < NT; j++) begin
      push(j == 0 ? 32 : 0, 0, 0, v, yi, yq);
      checks++; if (v !== 1'b1) begin errs++; $display("FAIL imp_valid[%0d]: got %b want 1", j, v); end
      checks++; if (yi != (j == 5 ? 128 : 0)) begin errs++; $display("FAIL imp_I[%0d]: got %0d want %0d", j, yi, j == 5 ? 128 : 0); end
      checks++; if (yq != 0) begin errs++; $display("FAIL imp_Q[%0d]: got %0d want 0", j, yq); end
    end
  endtask

  task automatic test_complex();
    bit v; int yi, yq;
    do_reset();
    taps_i = '0; taps_q = '0; set_tap(1, 0, ONE);
    load = 1; tick(); load = 0;
    push(32, 0, 0, v, yi, yq);
    checks++; if (yi != 0 || yq != 128) begin errs++; $display("FAIL cplx_a: got (%0d,%0d) want (0,128)", yi, yq); end
    push(0, 32, 0, v, yi, yq);
    checks++; if (yi != -128 || yq != 0) begin errs++; $display("FAIL cplx_b: got (%0d,%0d) want (-128,0)", yi, yq); end
  endtask

  task automatic test_rounding();
    bit v; int yi, yq;
    int xs[5] = '{3, 5, -5, 4, -4};
    int ws[5] = '{0, 1, -1, 1, 0};
    do_reset();
    taps_i = '0; taps_q = '0; set_tap(0, 0, 32'h0100000);
    load = 1; tick(); load = 0;
    for (int j = 0; j < 5; j++) begin
      push(xs[j], 0, 0, v, yi, yq);
      checks++; if (yi != ws[j]) begin errs++; $display("FAIL round[%0d]: in %0d got %0d want %0d", j, xs[j], yi, ws[j]); end
    end
  endtask

  task automatic test_saturation();
    bit v; int yi, yq;
    do_reset();
    taps_q = '0;
    for (int k = 0; k < NT; k++) set_tap(0, k, ONE);
    load = 1; tick(); load = 0;
    for (int j = 0; j < NT; j++) push(127, 0, 0, v, yi, yq);
    checks++; if (yi != OMAX) begin errs++; $display("FAIL sat_hi: got %0d want %0d", yi, OMAX); end
    tick();
    checks++; if (osat !== 1'b1) begin errs++; $display("FAIL sat_sticky: got %b want 1", osat); end
    clr = 1; tick(); clr = 0;
    checks++; if (osat !== 1'b0) begin errs++; $display("FAIL sat_clr: got %b want 0", osat); end
    for (int j = 0; j < NT; j++) push(-128, 0, 0, v, yi, yq);
    checks++; if (yi != OMIN) begin errs++; $display("FAIL sat_lo: got %0d want %0d", yi, OMIN); end
    checks++; if (osat !== 1'b1) begin errs++; $display("FAIL sat_lo_flag: got %b want 1", osat); end
  endtask

  task automatic test_tap_timing();
    bit v; int yi, yq;
    int want[4] = '{128, 64, 64, 32};
    do_reset();
    taps_i = '0; taps_q = '0; set_tap(0, 0, ONE);
    load = 1; tick(); load = 0;
    push(32, 0, 0, v, yi, yq);
    checks++; if (yi != 128) begin errs++; $display("FAIL tap_first: got %0d want 128", yi); end
    set_tap(0, 0, ONE / 2);
    load = 1; tick(); load = 0;
    checks++; if (opend !== 1'b1) begin errs++; $display("FAIL tap_pend_set: got %b want 1", opend); end
    for (int j = 0; j < 4; j++) begin
      if (j == 3) set_tap(0, 0, ONE / 4);
      push(32, 0, j == 3, v, yi, yq);
      checks++; if (yi != want[j]) begin errs++; $display("FAIL tap_seq[%0d]: got %0d want %0d", j, yi, want[j]); end
      checks++; if (opend !== (j == 0)) begin errs++; $display("FAIL tap_pend[%0d]: got %b want %b", j, opend, j == 0); end
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, pulses = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 3) != 0);
      di = 8'($urandom); dq = 8'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      load = ($urandom_range(0, 19) == 0) || (n == 0);
      if (load)
        for (int k = 0; k < NT; k++) begin
          set_tap(0, k, int'($urandom_range(0, 1 << 25)) - (1 << 24));
          set_tap(1, k, int'($urandom_range(0, 1 << 25)) - (1 << 24));
        end
      if (en && n < 396) acc++;
      else en = (n < 396) ? en : 1'b0;
      tick();
      if (ov === 1'b1) pulses++;
      checks++; if (ov !== m_valid) begin errs++; $display("FAIL b2b_valid[%0d]: got %b want %b", n, ov, m_valid); end
      checks++; if (osv !== m_sym) begin errs++; $display("FAIL b2b_sym[%0d]: got %b want %b", n, osv, m_sym); end
      checks++; if (int'(oi) != m_i || int'(oq) != m_q) begin errs++; $display("FAIL b2b_data[%0d]: got (%0d,%0d) want (%0d,%0d)", n, oi, oq, m_i, m_q); end
      checks++; if (osat !== m_sat) begin errs++; $display("FAIL b2b_sat[%0d]: got %b want %b", n, osat, m_sat); end
      checks++; if (opend !== m_pend) begin errs++; $display("FAIL b2b_pend[%0d]: got %b want %b", n, opend, m_pend); end
    end
    clr = 0; load = 0;
    checks++; if (pulses != acc) begin errs++; $display("FAIL b2b_count: got %0d want %0d", pulses, acc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    taps_q = '0;
    for (int k = 0; k < NT; k++) set_tap(0, k, ONE);
    load = 1; tick(); load = 0;
    for (int n = 0; n < 14; n++) begin en = 1; di = 8'sd100; dq = 8'($urandom); tick(); end
    en = 0; load = 1; tick(); load = 0;
    checks++; if (ov !== 1'b1 || osat !== 1'b1 || opend !== 1'b1) begin errs++; $display("FAIL mid_pre: got v%b s%b p%b want 111", ov, osat, opend); end
    #2 rst_n = 0; model_reset();
    #1;
    checks++; if (ov !== 1'b0 || osv !== 1'b0) begin errs++; $display("FAIL mid_valid: got %b%b want 00", ov, osv); end
    checks++; if (oi !== 12'sd0 || oq !== 12'sd0) begin errs++; $display("FAIL mid_data: got (%0d,%0d) want (0,0)", oi, oq); end
    checks++; if (osat !== 1'b0 || opend !== 1'b0) begin errs++; $display("FAIL mid_flags: got s%b p%b want 00", osat, opend); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++; if (ov !== 1'b0) begin errs++; $display("FAIL mid_idle[%0d]: got %b want 0", n, ov); end
    end
    taps_i = '0; set_tap(0, 0, ONE);
    load = 1; tick(); load = 0;
    en = 1; di = 8'sd32; dq = 0; tick(); en = 0; di = 0;
    checks++; if (ov !== 1'b0) begin errs++; $display("FAIL mid_e0: got %b want 0", ov); end
    tick();
    checks++; if (ov !== 1'b0) begin errs++; $display("FAIL mid_e1: got %b want 0", ov); end
    tick();
    checks++; if (ov !== 1'b1 || oi !== 12'sd128) begin errs++; $display("FAIL mid_e2: got v%b I%0d want v1 I128", ov, oi); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_complex();
    test_rounding();
    test_saturation();
    test_tap_timing();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
